// File: rtl/mod2011_stream_reducer.sv
// -----------------------------------------------------------------------------
// mod2011_stream_reducer
//
// Streaming residue engine: reduces a wide operand, delivered as 6-bit chunks
// most-significant chunk first, modulo MOD using one Horner step per accepted
// chunk:  acc = (acc * 2^CHUNK_W + chunk) mod MOD.
// The Horner step is built from CHUNK_W shift/conditional-subtract stages, so
// no multiplier or divider is needed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    input chunk valid
//   s_ready    reducer can accept a chunk (registered)
//   s_data     chunk value, MSB-first order
//   s_last     final (least-significant) chunk of the operand
//   m_valid    result valid (registered)
//   m_ready    result consumer ready
//   m_residue  operand mod MOD, always < MOD
//   m_count    chunks accepted for this operand, saturating at N_CHUNKS
//   m_len_err  operand carried more than N_CHUNKS chunks
//
// Result fields are loaded on the s_last beat and held until the result
// handshake completes. While a result is pending s_ready is low, so input is
// back-pressured and no chunk is absorbed.
// -----------------------------------------------------------------------------
module mod2011_stream_reducer #(
  parameter int MOD      = 2011,
  parameter int CHUNK_W  = 6,
  parameter int RES_W    = 11,
  parameter int N_CHUNKS = 84,
  parameter int CNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [RES_W-1:0]   m_residue,
  output logic [CNT_W-1:0]   m_count,
  output logic               m_len_err
);

  // Modulus widened by one bit so it compares directly against 2*r + bit.
  localparam logic [RES_W:0]   MOD_X   = (RES_W+1)'(MOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CHUNKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [RES_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               len_err;

  logic               beat;
  logic [RES_W-1:0]   acc_step;
  logic [RES_W-1:0]   first_val;
  logic [CNT_W-1:0]   count_next;
  logic               len_err_next;

  // One Horner step: fold the chunk bits into the residue MSB first. Each
  // stage input is < MOD, so 2*r + bit < 2*MOD and a single conditional
  // subtract restores the invariant. RES_W+1 bits hold the intermediate.
  function automatic logic [RES_W-1:0] step(input logic [RES_W-1:0]   a,
                                            input logic [CHUNK_W-1:0] d);
    logic [RES_W:0]   t;
    logic [RES_W-1:0] r;
    r = a;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      t = {r, d[i]};
      if (t >= MOD_X) begin
        t = t - MOD_X;
      end else begin
        t = t;
      end
      r = t[RES_W-1:0];
    end
    return r;
  endfunction

  // Datapath next-value logic shared by the state machine.
  always_comb begin
    beat         = s_valid && s_ready;
    acc_step     = step(acc, s_data);
    // A lone chunk is already below MOD (2^CHUNK_W <= MOD), so no reduction.
    first_val    = {{(RES_W-CHUNK_W){1'b0}}, s_data};
    count_next   = count;
    len_err_next = len_err;
    if (count == CNT_MAX) begin
      // Beat beyond the legal length: flag it, keep the count saturated.
      count_next   = count;
      len_err_next = 1'b1;
    end else begin
      count_next   = count + CNT_ONE;
      len_err_next = len_err;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len_err   <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_residue <= '0;
      m_count   <= '0;
      m_len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          if (beat) begin
            acc     <= first_val;
            count   <= CNT_ONE;
            len_err <= 1'b0;
            if (s_last) begin
              state     <= DONE;
              s_ready   <= 1'b0;
              m_valid   <= 1'b1;
              m_residue <= first_val;
              m_count   <= CNT_ONE;
              m_len_err <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end else begin
            state <= IDLE;
          end
        end

        ACCUM: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          if (beat) begin
            acc     <= acc_step;
            count   <= count_next;
            len_err <= len_err_next;
            if (s_last) begin
              state     <= DONE;
              s_ready   <= 1'b0;
              m_valid   <= 1'b1;
              m_residue <= acc_step;
              m_count   <= count_next;
              m_len_err <= len_err_next;
            end else begin
              state <= ACCUM;
            end
          end else begin
            state <= ACCUM;
          end
        end

        DONE: begin
          // Result fields stay frozen until the consumer takes them.
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end else begin
            state   <= DONE;
            m_valid <= 1'b1;
            s_ready <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod2011_stream_reducer.sv
// -----------------------------------------------------------------------------
// tb_mod2011_stream_reducer
//
// Directed and random operands are streamed into the reducer; each result is
// compared against a reference computed with plain integer mod-2011 arithmetic.
// -----------------------------------------------------------------------------
module tb_mod2011_stream_reducer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [10:0] m_residue;
  logic [6:0]  m_count;
  logic        m_len_err;

  int n_assert = 0;
  int n_fail   = 0;
  int op [0:127];

  always #5 clk = ~clk;

  mod2011_stream_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_residue (m_residue),
    .m_count   (m_count),
    .m_len_err (m_len_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one chunk and wait (bounded) until it is accepted; afterwards
  // junk is left on the data lines with s_valid low.
  task automatic send_beat(input int d, input bit last);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d[5:0];
    s_last  = last;
    while (s_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("s_ready_timeout", int'(t < 200), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 6'($urandom);
    s_last  = 1'($urandom);
  endtask

  // Stream op[0..n-1]; gap_max idle cycles between beats, then check result
  // with `stall` cycles of m_ready low. exp_res >= 0 also pins the residue.
  task automatic run_op(input string tag, input int n, input int gap_max,
                        input int stall, input int exp_res);
    int r, e_cnt, e_err, g;
    r = 0;
    for (int i = 0; i < n; i++) r = (r * 64 + op[i]) % 2011;
    e_cnt = (n > 84) ? 84 : n;
    e_err = (n > 84) ? 1 : 0;
    if (exp_res >= 0) chk({tag, "_model"}, r, exp_res);
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_beat(op[i], (i == n - 1));
      if (i != n - 1) begin
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
      end
    end
    // Result must be up the cycle after the last beat.
    chk({tag, "_m_valid"}, int'(m_valid), 1);
    chk({tag, "_residue"}, int'(m_residue), r);
    chk({tag, "_count"}, int'(m_count), e_cnt);
    chk({tag, "_len_err"}, int'(m_len_err), e_err);
    // Offer junk input during the stall; it must not be taken.
    s_valid = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, int'(m_valid), 1);
      chk({tag, "_stall_residue"}, int'(m_residue), r);
      chk({tag, "_stall_s_ready"}, int'(s_ready), 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk({tag, "_after_valid"}, int'(m_valid), 0);
    chk({tag, "_after_s_ready"}, int'(s_ready), 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 6'd0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_residue", int'(m_residue), 0);
    chk("rst_m_count", int'(m_count), 0);
    chk("rst_m_len_err", int'(m_len_err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_ready", int'(s_ready), 1);

    op[0] = 63;
    run_op("single", 1, 0, 0, 63);
    op[0] = 31; op[1] = 27;
    run_op("mult", 2, 0, 0, 0);
    op[0] = 31; op[1] = 63;
    run_op("v2047", 2, 0, 0, 36);
    op[0] = 1; op[1] = 0; op[2] = 0;
    run_op("v4096", 3, 0, 0, 74);
    run_op("bp", 3, 0, 5, 74);
    op[0] = 31; op[1] = 63;
    run_op("gaps", 2, 3, 0, 36);
    for (int i = 0; i < 85; i++) op[i] = 0;
    run_op("over", 85, 0, 0, 0);
    op[0] = 5;
    run_op("fresh", 1, 0, 0, 5);

    // Reset during an operand: partial data is dropped.
    send_beat(31, 1'b0);
    send_beat(63, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    op[0] = 1; op[1] = 0; op[2] = 0;
    run_op("post_rst", 3, 0, 0, 74);

    // Reset while a result is pending: m_valid drops without a clock edge.
    s_valid = 1'b1; s_data = 6'd9; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("pend_m_valid", int'(m_valid), 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("pend_rst_m_valid", int'(m_valid), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 25; t++) begin
      int n;
      n = int'($urandom_range(90, 1));
      for (int i = 0; i < n; i++) op[i] = int'($urandom_range(63, 0));
      run_op("rand", n, 2, int'($urandom_range(3, 0)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod2011_stream_reducer.md
Name: mod2011_stream_reducer

Overview:
- Serial counterpart of the parallel mod-2011 chunk-LUT network.
- Accepts a wide operand (up to 500 bits, padded to 504) as a stream of 6-bit chunks, most-significant chunk first.
- Accumulates the residue mod 2011 with Horner steps, one chunk per cycle: acc = (acc*64 + chunk) mod 2011.
- Returns the 11-bit residue over a valid/ready result port. Used as the streaming source and as the golden cross-check for the LUT-bank residues.

Parameters:
- MOD, 2011, modulus; must satisfy 64 <= MOD < 2^RES_W.
- CHUNK_W, 6, chunk width in bits.
- RES_W, 11, residue width.
- N_CHUNKS, 84, maximum legal chunks per operand (504 bits).
- CNT_W, 7, chunk-counter width; must hold N_CHUNKS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input chunk valid.
- s_ready  out  1  reducer can accept a chunk.
- s_data  in  CHUNK_W  chunk value, MSB-first order.
- s_last  in  1  marks the final (least-significant) chunk of the operand.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_residue  out  RES_W  operand mod MOD, always < MOD.
- m_count  out  CNT_W  chunks accepted for this operand, saturating at N_CHUNKS.
- m_len_err  out  1  operand exceeded N_CHUNKS chunks.

Behaviour:
- One clock, clk. rst_n is asynchronous assert, synchronous deassert (deassertion synchronised externally).
- Reset values: state=IDLE, acc=0, count=0, len_err=0, s_ready=0 during reset, m_valid=0, m_residue=0, m_count=0, m_len_err=0.
- Handshakes:
  - Input beat transfers when s_valid && s_ready. Result transfers when m_valid && m_ready.
  - Once m_valid rises, m_residue, m_count and m_len_err are held stable until the transfer.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: s_ready=1, m_valid=0. On a beat: acc <= s_data, count <= 1, len_err <= 0. Then go to DONE if s_last, otherwise ACCUM.
  - ACCUM: s_ready=1. On a beat: acc <= step(acc, s_data), and count <= count+1, saturating at N_CHUNKS.
    - If a beat arrives while count == N_CHUNKS, set len_err <= 1. Keep accumulating regardless (the residue stays mathematically correct).
    - If s_last, go to DONE. With no beat, hold everything.
  - DONE: s_ready=0, m_valid=1. On m_ready, go to IDLE. Next operand's first beat is accepted no earlier than the cycle after the result transfer.
- step(a, d), combinational, single cycle:
  - Six unrolled shift/conditional-subtract stages, consuming the bits of d MSB first.
  - Each stage: t = 2*r + bit; if t >= MOD then t -= MOD.
  - Stage input r < MOD, so t < 2*MOD; 12-bit intermediates suffice. Output is always < MOD.
  - No multiplier, no division.
- Latency and throughput:
  - Result valid the cycle after the s_last beat.
  - Throughput is one chunk per cycle. A k-chunk operand occupies k + 1 + (m_ready wait) cycles.
- Boundaries:
  - Single-beat operand (s_last on first beat): residue = s_data, since s_data < 64 < MOD.
  - Operand value equal to a multiple of MOD gives residue 0.
  - s_valid low between beats leaves acc and count unchanged.
  - s_data and s_last are ignored when not transferring.
  - m_ready held low stalls indefinitely in DONE. Input is back-pressured, and no beat is lost or absorbed.
  - Reset asserted mid-operand or mid-result returns to IDLE immediately. The partial operand is discarded and m_valid drops asynchronously.

Test Plan:
- Single beat s_data=0x3F, s_last=1, m_ready=1 -> next cycle m_valid=1, m_residue=63, m_count=1, m_len_err=0; then IDLE with s_ready=1.
- Beats [31,27] (value 2011) -> m_residue=0, m_count=2. Beats [31,63] (2047) -> m_residue=36. Beats [1,0,0] (4096) -> m_residue=74.
- Backpressure: beats [1,0,0] with m_ready=0 for 5 cycles -> m_valid stays 1, residue held at 74, s_ready=0 throughout; transfer on cycle m_ready=1; IDLE next cycle.
- Gaps: beats [31,63] with s_valid low for 3 cycles between beats and junk on s_data/s_last during the gaps -> m_residue=36, m_count=2.
- Overlength: 85 zero beats, last flagged -> m_residue=0, m_count=84, m_len_err=1. Then a fresh beat [5] last -> m_residue=5, m_len_err=0.
- Reset mid-stream: beats [31,63] without last, pulse rst_n low -> m_valid=0 and state IDLE. Then beats [1,0,0] -> m_residue=74, m_count=3. The random-operand bench compares against a mod-2011 reference model.
